// File: rtl/lstm_step_sequencer.sv
// Feeds buffered feature samples to the LSTM network one timestep at a time.
// It waits out the network latency and hands each hidden output downstream over valid/ready.
module lstm_step_sequencer #(
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned LSTM_LAT   = 4,
   parameter int unsigned MAX_STEPS  = 255
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       s_valid_i,
   output logic       s_ready_o,
   input  logic [7:0] s_data_i,
   input  logic       s_last_i,
   output logic [7:0] lstm_in_o,
   output logic [7:0] lstm_add_o,
   output logic       lstm_cen_o,
   output logic       lstm_first_o,
   input  logic [7:0] lstm_hout_i,
   input  logic       lstm_of_i,
   output logic       h_valid_o,
   input  logic       h_ready_i,
   output logic [7:0] h_data_o,
   output logic       h_last_o,
   output logic       ovf_sticky_o,
   output logic       busy_o
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned LW = (LSTM_LAT > 1) ? $clog2(LSTM_LAT) : 1;
   localparam logic [CW-1:0] Full    = CW'(FIFO_DEPTH);
   localparam logic [LW-1:0] LastCnt = LW'(LSTM_LAT - 1);
   localparam logic [7:0]    MaxStep = 8'(MAX_STEPS);

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StOut} state_e;

   state_e          state_q;
   logic [8:0]      mem_q [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]   count_q, count_d;
   logic            push, pop;
   logic [8:0]      head;
   logic [7:0]      step_q;
   logic            first_pending_q, cur_last_q;
   logic [LW-1:0]   cnt_q;
   logic [7:0]      lstm_in_q, lstm_add_q, h_data_q;
   logic            lstm_cen_q, lstm_first_q, h_valid_q, h_last_q, ovf_q;

   // No bypass: a full FIFO refuses even when the head is being popped.
   assign s_ready_o = (count_q != Full);
   assign push      = s_valid_i && s_ready_o;
   assign pop       = (state_q == StIssue);
   assign head      = mem_q[rd_ptr_q];

   always_comb begin
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + CW'(1);
      end else if (pop && !push) begin
         count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {s_last_i, s_data_i};
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q         <= StIdle;
         step_q          <= '0;
         first_pending_q <= 1'b1;
         cur_last_q      <= 1'b0;
         cnt_q           <= '0;
         lstm_in_q       <= '0;
         lstm_add_q      <= '0;
         lstm_first_q    <= 1'b0;
         lstm_cen_q      <= 1'b0;
         h_valid_q       <= 1'b0;
         h_data_q        <= '0;
         h_last_q        <= 1'b0;
         ovf_q           <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (count_q != '0) begin
                  state_q <= StIssue;
               end
            end
            StIssue: begin
               lstm_in_q       <= head[7:0];
               lstm_add_q      <= step_q;
               lstm_first_q    <= first_pending_q;
               cur_last_q      <= head[8];
               first_pending_q <= 1'b0;
               cnt_q           <= '0;
               lstm_cen_q      <= 1'b1;
               state_q         <= StWait;
            end
            StWait: begin
               if (cnt_q == LastCnt) begin
                  h_data_q   <= lstm_hout_i;
                  h_last_q   <= cur_last_q;
                  ovf_q      <= ovf_q | lstm_of_i;
                  lstm_cen_q <= 1'b0;
                  h_valid_q  <= 1'b1;
                  state_q    <= StOut;
               end else begin
                  cnt_q <= cnt_q + LW'(1);
               end
            end
            StOut: begin
               if (h_ready_i) begin
                  h_valid_q <= 1'b0;
                  state_q   <= StIdle;
                  if (cur_last_q) begin
                     step_q          <= '0;
                     first_pending_q <= 1'b1;
                  end else if (step_q == MaxStep) begin
                     // Utterance longer than the weight table: wrap and flag it.
                     step_q <= '0;
                     ovf_q  <= 1'b1;
                  end else begin
                     step_q <= step_q + 8'd1;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign lstm_in_o    = lstm_in_q;
   assign lstm_add_o   = lstm_add_q;
   assign lstm_cen_o   = lstm_cen_q;
   assign lstm_first_o = lstm_first_q;
   assign h_valid_o    = h_valid_q;
   assign h_data_o     = h_data_q;
   assign h_last_o     = h_last_q;
   assign ovf_sticky_o = ovf_q;
   assign busy_o       = (state_q != StIdle) || (count_q != '0);

endmodule

// File: tb/tb_lstm_step_sequencer.sv
// Scoreboard bench for lstm_step_sequencer.
// The network model returns in ^ add ^ (cycles since enable << 4), so a capture on the wrong cycle shows up.
module tb_lstm_step_sequencer;

   localparam int LAT = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       s_valid = 1'b0, s_last = 1'b0, h_ready = 1'b1, of_en = 1'b0;
   logic [7:0] s_data = 8'h00;
   logic       s_ready, lstm_cen, lstm_first, lstm_of, h_valid, h_last, ovf_sticky, busy;
   logic [7:0] lstm_in, lstm_add, lstm_hout, h_data;
   logic [3:0] cen_run = 4'd0;

   always #5 clk = ~clk;

   lstm_step_sequencer #(.FIFO_DEPTH(8), .LSTM_LAT(LAT), .MAX_STEPS(255)) dut (
      .clk_i(clk), .rst_i(rst), .s_valid_i(s_valid), .s_ready_o(s_ready), .s_data_i(s_data),
      .s_last_i(s_last), .lstm_in_o(lstm_in), .lstm_add_o(lstm_add), .lstm_cen_o(lstm_cen),
      .lstm_first_o(lstm_first), .lstm_hout_i(lstm_hout), .lstm_of_i(lstm_of),
      .h_valid_o(h_valid), .h_ready_i(h_ready), .h_data_o(h_data), .h_last_o(h_last),
      .ovf_sticky_o(ovf_sticky), .busy_o(busy)
   );

   always @(posedge clk) cen_run <= lstm_cen ? 4'(cen_run + 4'd1) : 4'd0;
   assign lstm_hout = lstm_in ^ lstm_add ^ {cen_run, 4'h0};
   assign lstm_of   = of_en && lstm_cen && (cen_run == 4'(LAT - 1)) && (lstm_add == 8'd2);

   typedef struct {logic [7:0] d; logic [7:0] a; logic f;} iss_t;
   typedef struct {logic [7:0] h; logic l;} res_t;
   typedef struct {string name; int id; int act; int exp;} chk_t;

   localparam int IdFlag = 0, IdOvf = 1, IdReady = 2, IdHv = 3, IdCen = 4, IdBusy = 5,
                  IdHdata = 6, IdAdd = 7, IdFirst = 8;

   iss_t iq[$];
   res_t hq[$];
   chk_t dq[$];
   int   m_step = 0;
   logic m_first = 1'b1;
   int   n_checks = 0, n_err = 0;

   function automatic int dut_val(input int id);
      case (id)
         IdOvf:   return int'(ovf_sticky);
         IdReady: return int'(s_ready);
         IdHv:    return int'(h_valid);
         IdCen:   return int'(lstm_cen);
         IdBusy:  return int'(busy);
         IdHdata: return int'(h_data);
         IdAdd:   return int'(lstm_add);
         IdFirst: return int'(lstm_first);
         default: return -1;
      endcase
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: all comparisons happen here, on the falling edge.
   int   cen_len = 0, cyc = 0, cen_start = 0;
   logic hv_prev = 1'b0;
   always @(negedge clk) begin
      chk_t c;
      iss_t ie;
      res_t re;
      cyc++;
      while (dq.size() > 0) begin
         c = dq.pop_front();
         check(c.name, (c.id == IdFlag) ? c.act : dut_val(c.id), c.exp);
      end
      if (rst) begin
         cen_len = 0;
         hv_prev = 1'b0;
      end else begin
         if (lstm_cen) begin
            if (cen_len == 0) begin
               cen_start = cyc;
               check("issue_expected", int'(iq.size() > 0), 1);
               if (iq.size() > 0) begin
                  ie = iq.pop_front();
                  check("lstm_in", int'(lstm_in), int'(ie.d));
                  check("lstm_add", int'(lstm_add), int'(ie.a));
                  check("lstm_first", int'(lstm_first), int'(ie.f));
               end
            end
            cen_len++;
         end else if (cen_len != 0) begin
            check("cen_len", cen_len, LAT);
            cen_len = 0;
         end
         if (h_valid && !hv_prev) check("latency", cyc - cen_start, LAT);
         if (h_valid && h_ready) begin
            check("result_expected", int'(hq.size() > 0), 1);
            if (hq.size() > 0) begin
               re = hq.pop_front();
               check("h_data", int'(h_data), int'(re.h));
               check("h_last", int'(h_last), int'(re.l));
            end
         end
         hv_prev = h_valid;
      end
   end

   task automatic post(input string name, input int id, input int exp);
      dq.push_back('{name, id, 0, exp});
   endtask

   task automatic post_flag(input string name, input logic ok);
      dq.push_back('{name, IdFlag, int'(ok), 1});
   endtask

   task automatic send(input logic [7:0] d, input logic l);
      int w = 0;
      s_valid = 1'b1;
      s_data  = d;
      s_last  = l;
      @(negedge clk);
      while (!s_ready && w < 500) begin
         w++;
         @(negedge clk);
      end
      post_flag("send_accept", w < 500);
      if (w < 500) begin
         iq.push_back('{d, 8'(m_step), m_first});
         hq.push_back('{d ^ 8'(m_step) ^ {4'(LAT - 1), 4'h0}, l});
         m_first = l;
         if (l || m_step == 255) m_step = 0;
         else m_step++;
      end
      @(posedge clk);
      #1 s_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int w = 0;
      do begin
         @(posedge clk);
         w++;
      end while ((busy || iq.size() > 0 || hq.size() > 0) && w < 3000);
      #1 post_flag("drain", w < 3000);
   endtask

   task automatic do_reset();
      s_valid = 1'b0;
      rst = 1'b1;
      iq.delete();
      hq.delete();
      m_step  = 0;
      m_first = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      post("rst_h_valid", IdHv, 0);
      post("rst_cen", IdCen, 0);
      post("rst_s_ready", IdReady, 1);
      post("rst_busy", IdBusy, 0);
      post("rst_ovf", IdOvf, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_err);
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      repeat (3) @(posedge clk);
      #1 do_reset();
      post("rst_add", IdAdd, 0);
      post("rst_first", IdFirst, 0);

      // T1: single sample
      send(8'h10, 1'b0);
      wait_idle();
      do_reset();

      // T2: utterance of three, then a fresh one
      send(8'h21, 1'b0);
      send(8'h22, 1'b0);
      send(8'h23, 1'b1);
      send(8'h24, 1'b1);
      wait_idle();

      // T3: backpressure fills the FIFO behind one held result
      h_ready = 1'b0;
      for (int i = 0; i < 9; i++) send(8'(8'h41 + i), 1'b0);
      post("full_s_ready", IdReady, 0);
      post("held_h_valid", IdHv, 1);
      post("held_h_data", IdHdata, 8'h71);
      repeat (20) @(posedge clk);
      #1 post("stable_h_data", IdHdata, 8'h71);
      post("stall_s_ready", IdReady, 0);
      h_ready = 1'b1;
      send(8'h4A, 1'b1);
      wait_idle();

      // T4: network overflow on step 2
      post("ovf_before", IdOvf, 0);
      of_en = 1'b1;
      for (int i = 0; i < 4; i++) send(8'(8'h51 + i), (i == 3));
      wait_idle();
      of_en = 1'b0;
      post("ovf_set", IdOvf, 1);
      send(8'h60, 1'b1);
      wait_idle();
      post("ovf_sticky", IdOvf, 1);
      do_reset();

      // T5: step index wraps after 256 samples without last
      for (int i = 0; i < 255; i++) send(8'(i), 1'b0);
      wait_idle();
      post("ovf_pre_wrap", IdOvf, 0);
      send(8'hEE, 1'b0);
      wait_idle();
      post("ovf_wrap", IdOvf, 1);
      send(8'hEF, 1'b0);
      wait_idle();

      // T6: reset while the network is busy
      send(8'h81, 1'b0);
      send(8'h82, 1'b0);
      send(8'h83, 1'b0);
      w = 0;
      while (!lstm_cen && w < 100) begin
         @(posedge clk);
         #1 w++;
      end
      post_flag("found_wait", w < 100);
      @(posedge clk);
      #1 do_reset();
      send(8'h90, 1'b1);
      wait_idle();

      post_flag("queues_empty", iq.size() == 0 && hq.size() == 0);
      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
